// File: rtl/nn_dense_layer_param_pkg.sv
// Shared types and helpers for the dense layer: activation/state enums,
// width helpers and the shift/activate/clamp stage applied to each accumulator.
package nn_layer_pkg;

  typedef enum logic [1:0] {
    ACT_ID    = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2
  } act_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_BIAS,
    S_EMIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic signed [31:0] data;
    logic               sat;
  } sat_res_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough that N_IN full products plus the shifted bias never overflow.
  function automatic int acc_w(input int n_in, input int data_w);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

  function automatic act_e to_act(input logic [1:0] sel);
    case (sel)
      2'd1:    return ACT_RELU;
      2'd2:    return ACT_LEAKY;
      default: return ACT_ID;
    endcase
  endfunction

  function automatic sat_res_t sat_trunc(input logic signed [63:0] acc,
                                         input int data_w,
                                         input int frac_bits,
                                         input act_e act);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           res;
    r     = acc >>> frac_bits;
    if (act == ACT_RELU && r < 0)
      r = '0;
    else if (act == ACT_LEAKY && r < 0)
      r = r >>> 3;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    res.sat = 1'b0;
    if (r > max_v) begin
      r       = max_v;
      res.sat = 1'b1;
    end else if (r < min_v) begin
      r       = min_v;
      res.sat = 1'b1;
    end
    res.data = r[31:0];
    return res;
  endfunction

endpackage

// File: rtl/nn_dense_layer_param_if.sv
// Input-fetch and result-stream signals of the dense layer; master is the layer.
interface nn_dense_layer_param_if #(
  parameter int IN_AW  = 1,
  parameter int OUT_AW = 1,
  parameter int DATA_W = 8
);
  logic                     in_req;
  logic [IN_AW-1:0]         in_addr;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_AW-1:0]        out_idx;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  modport master (
    output in_req, in_addr, out_valid, out_idx, out_data, out_sat,
    input  in_data, out_ready
  );

  modport slave (
    input  in_req, in_addr, out_valid, out_idx, out_data, out_sat,
    output in_data, out_ready
  );
endinterface

// File: rtl/nn_dense_layer_param_mac_lane.sv
// One neuron's accumulator: full-precision multiply-accumulate plus Q-aligned bias add.
module nn_mac_lane #(
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     mac_en,
  input  logic                     bias_en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    bias_sh;

  assign prod    = x * w;
  assign bias_sh = ACC_W'(b) <<< FRAC_BITS;

  always_ff @(posedge clk) begin
    if (rst || clear)
      acc <= '0;
    else if (mac_en)
      acc <= acc + ACC_W'(prod);
    else if (bias_en)
      acc <= acc + bias_sh;
  end
endmodule

// File: rtl/nn_dense_layer_param.sv
// Dense layer top: sequencing FSM, weight/bias memories, input fetch and result stream.
//   state   | meaning
//   S_IDLE  | waiting for req; weight/bias writes accepted
//   S_FETCH | in_req strobe for input i
//   S_MAC   | in_data arrives; every lane accumulates x*w
//   S_BIAS  | every lane adds its bias
//   S_EMIT  | stream one neuron result per accepted beat
//   S_DONE  | one-cycle done pulse
module nn_dense_layer_param
  import nn_layer_pkg::*;
#(
  parameter  int N_IN      = 2,
  parameter  int N_OUT     = 2,
  parameter  int DATA_W    = 8,
  parameter  int FRAC_BITS = 4,
  localparam int IN_AW     = idx_w(N_IN),
  localparam int W_AW      = idx_w(N_IN * N_OUT),
  localparam int OUT_AW    = idx_w(N_OUT),
  localparam int ACC_W     = acc_w(N_IN, DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [1:0]               act_sel,
  output logic                     busy,
  input  logic                     w_we,
  input  logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     b_we,
  input  logic [OUT_AW-1:0]        b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     done,
  nn_dense_layer_param_if.master   io
);
  state_e                   state, state_nx;
  logic [IN_AW-1:0]         i_q;
  logic [OUT_AW-1:0]        idx_q;
  act_e                     act_q;
  logic                     start, mac_en, bias_en, i_inc, idx_inc;
  logic                     last_in, last_out;
  logic signed [DATA_W-1:0] w_mem [N_IN*N_OUT];
  logic signed [DATA_W-1:0] b_mem [N_OUT];
  logic signed [ACC_W-1:0]  acc   [N_OUT];
  sat_res_t                 res;
  logic                     unused_res_bits;

  assign last_in  = (int'(i_q) == N_IN - 1);
  assign last_out = (int'(idx_q) == N_OUT - 1);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    mac_en   = 1'b0;
    bias_en  = 1'b0;
    i_inc    = 1'b0;
    idx_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          start    = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_MAC;
      S_MAC: begin
        mac_en = 1'b1;
        if (last_in) begin
          state_nx = S_BIAS;
        end else begin
          i_inc    = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_BIAS: begin
        bias_en  = 1'b1;
        state_nx = S_EMIT;
      end
      S_EMIT: begin
        if (io.out_ready) begin
          if (last_out) state_nx = S_DONE;
          else          idx_inc  = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      i_q   <= '0;
      idx_q <= '0;
      act_q <= ACT_ID;
    end else begin
      state <= state_nx;
      if (start) begin
        i_q   <= '0;
        idx_q <= '0;
        act_q <= to_act(act_sel);
      end else begin
        if (i_inc)   i_q   <= i_q + 1'b1;
        if (idx_inc) idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Memories survive reset; writes only land while idle and in range.
  always_ff @(posedge clk) begin
    if (w_we && !busy && int'(w_addr) < N_IN * N_OUT)
      w_mem[w_addr] <= w_data;
    if (b_we && !busy && int'(b_addr) < N_OUT)
      b_mem[b_addr] <= b_data;
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    logic [W_AW-1:0] w_idx;
    assign w_idx = W_AW'(j * N_IN) + W_AW'(i_q);
    nn_mac_lane #(
      .DATA_W   (DATA_W),
      .FRAC_BITS(FRAC_BITS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (start),
      .mac_en (mac_en),
      .bias_en(bias_en),
      .x      (io.in_data),
      .w      (w_mem[w_idx]),
      .b      (b_mem[j]),
      .acc    (acc[j])
    );
  end

  assign res             = sat_trunc(64'(acc[idx_q]), DATA_W, FRAC_BITS, act_q);
  assign unused_res_bits = ^res.data[31:DATA_W];

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign io.in_req    = (state == S_FETCH);
  assign io.in_addr   = i_q;
  assign io.out_valid = (state == S_EMIT);
  assign io.out_idx   = idx_q;
  assign io.out_data  = io.out_valid ? res.data[DATA_W-1:0] : '0;
  assign io.out_sat   = io.out_valid & res.sat;
endmodule

// File: tb/tb_nn_dense_layer_param.sv
// Bench for nn_dense_layer_param (N_IN=2, N_OUT=2, Q4.4): vector table plus stall, busy-write and abort sequences.
module tb_nn_dense_layer_param;
  logic              clk = 1'b0;
  logic              rst, req, w_we, b_we, busy, done;
  logic [1:0]        act_sel, w_addr;
  logic              b_addr;
  logic signed [7:0] w_data, b_data;

  always #5 clk = ~clk;

  nn_dense_layer_param_if #(.IN_AW(1), .OUT_AW(1), .DATA_W(8)) io ();

  nn_dense_layer_param #(.N_IN(2), .N_OUT(2), .DATA_W(8), .FRAC_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .act_sel(act_sel), .busy(busy),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .done(done), .io(io)
  );

  typedef struct {
    logic signed [7:0] w [4];
    logic signed [7:0] b [2];
    logic signed [7:0] x [2];
    logic [1:0]        act;
    int                e0, e1, s0, s1;
  } vec_t;

  typedef struct {
    int idx;
    int data;
    int sat;
  } exp_t;

  int                checks = 0;
  int                failures = 0;
  exp_t              sbq [$];
  logic signed [7:0] x_cur [2];
  vec_t              tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int w0, w1, w2, w3, b0, b1, x0, x1, act,
                              input int e0, s0, e1, s1);
    vec_t v;
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    v.b[0] = 8'(b0); v.b[1] = 8'(b1);
    v.x[0] = 8'(x0); v.x[1] = 8'(x1);
    v.act  = 2'(act);
    v.e0 = e0; v.s0 = s0; v.e1 = e1; v.s1 = s1;
    return v;
  endfunction

  // Previous-layer model: answer the fetch strobe during the FETCH cycle.
  always @(negedge clk) if (io.in_req) io.in_data = x_cur[io.in_addr];

  always @(negedge clk) begin
    exp_t e;
    if (io.out_valid && io.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output idx=%0d data=%0d", io.out_idx, $signed(io.out_data));
      end else begin
        e = sbq.pop_front();
        chk("out_idx", int'(io.out_idx), e.idx);
        chk("out_data", int'($signed(io.out_data)), e.data);
        chk("out_sat", int'(io.out_sat), e.sat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      w_we = 1'b1; w_addr = 2'(k); w_data = v.w[k];
      step();
    end
    w_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b_we = 1'b1; b_addr = 1'(k); b_data = v.b[k];
      step();
    end
    b_we = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    sbq.push_back('{0, v.e0, v.s0});
    sbq.push_back('{1, v.e1, v.s1});
  endtask

  // Returns one cycle after the edge that sampled req; act_sel is then disturbed.
  task automatic start(input logic [1:0] a);
    req = 1'b1; act_sel = a;
    step();
    req = 1'b0; act_sel = ~a;
  endtask

  task automatic wait_done(input string name, output int first_k, output int done_k);
    first_k = -1;
    done_k  = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (io.out_valid && first_k < 0) first_k = k;
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout actual=none required=pulse", name);
    end
    step();
  endtask

  task automatic run_vec(input vec_t v, input string name, input bit do_load);
    int first_k, done_k;
    if (do_load) load(v);
    x_cur = v.x;
    push_exp(v);
    start(v.act);
    wait_done(name, first_k, done_k);
    chk({name, "_first_valid_edge"}, first_k, 5);
    chk({name, "_done_edge"}, done_k, 7);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, int'(done), 0);
    chk({name, "_idle_after"}, int'(busy), 0);
    chk({name, "_drained"}, sbq.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k, done_k, bad;
    tbl[0] = mk(-12, 12, 17, -17,   0, 0,  16,   0, 0,  -12, 0,   17, 0);
    tbl[1] = mk(-12, 12, 17, -17,   0, 0,   0,  16, 1,   12, 0,    0, 0);
    tbl[2] = mk(-12, 12, 17, -17,   0, 0,  16,   0, 2,   -2, 0,   17, 0);
    tbl[3] = mk(127, 127, 127, 127, 0, 0, 127, 127, 0,  127, 1,  127, 1);
    tbl[4] = mk(-128, -128, -128, -128, 0, 0, 127, 127, 0, -128, 1, -128, 1);
    tbl[5] = mk(-12, 12, 17, -17,  16, 0,  16,   0, 3,    4, 0,   17, 0);
    tbl[6] = mk(-128, -128, -128, -128, 0, 0, 127, 127, 2, -128, 1, -128, 1);

    rst = 1'b1; req = 1'b0; act_sel = 2'd0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    b_we = 1'b0; b_addr = '0; b_data = '0;
    io.out_ready = 1'b1; io.in_data = '0;
    x_cur[0] = '0; x_cur[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_req", int'(io.in_req), 0);
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_out_sat", int'(io.out_sat), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_addr", int'(io.in_addr), 0);
    chk("rst_out_idx", int'(io.out_idx), 0);
    chk("rst_out_data", int'($signed(io.out_data)), 0);
    step();

    for (int n = 0; n < 7; n++) run_vec(tbl[n], $sformatf("vec%0d", n), 1'b1);

    // Consumer stalls on idx0 while a second req arrives.
    load(tbl[0]);
    x_cur = tbl[0].x;
    push_exp(tbl[0]);
    io.out_ready = 1'b0;
    start(2'd0);
    first_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (io.out_valid) begin
        first_k = k;
        break;
      end
    end
    chk("stall_first_valid_edge", first_k, 5);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1 req = (s == 0);
      @(negedge clk);
      chk("stall_valid", int'(io.out_valid), 1);
      chk("stall_idx", int'(io.out_idx), 0);
      chk("stall_data", int'($signed(io.out_data)), -12);
      chk("stall_sat", int'(io.out_sat), 0);
      chk("stall_no_done", int'(done), 0);
    end
    @(posedge clk);
    #1 req = 1'b0; io.out_ready = 1'b1;
    wait_done("stall", first_k, done_k);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) bad++;
    end
    chk("busy_req_ignored", bad, 0);
    chk("stall_drained", sbq.size(), 0);
    step();

    // Writes while busy must not reach this run or the next.
    x_cur = tbl[0].x;
    push_exp(tbl[0]);
    start(2'd0);
    w_we = 1'b1; w_addr = 2'd0; w_data = 8'sd50;
    b_we = 1'b1; b_addr = 1'b0; b_data = 8'sd100;
    step();
    step();
    w_we = 1'b0; b_we = 1'b0;
    wait_done("busy_write", first_k, done_k);
    run_vec(tbl[0], "after_busy_write", 1'b0);

    // Abort in MAC of the last input, then a clean run.
    x_cur = tbl[0].x;
    start(2'd0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_req", int'(io.in_req), 0);
    chk("abort_out_valid", int'(io.out_valid), 0);
    chk("abort_in_addr", int'(io.in_addr), 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || io.out_valid || busy) bad++;
    end
    chk("abort_quiet", bad, 0);
    step();
    run_vec(tbl[0], "after_abort", 1'b0);
    run_vec(tbl[2], "after_abort_leaky", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
